clock_phase_gen: RTL and testbench
==================================

Name: clock_phase_gen

Overview:
- Parametrised, single-clock successor to the fixed divide-by-2/divide-by-4 clock tree that feeds the imem, dmem, regfile and processor domains.
- Generates NUM_CH independent clock-enable strobes and square-wave levels. Each channel has a runtime-programmable period and phase.
- Supports run, pause/single-step and phase-resync control, so memory and processor stages can be sequenced without derived clocks.

Parameters:
- NUM_CH, 4, number of output channels (>=1).
- CNT_W, 8, width of per-channel divide and phase fields.
- CH_W, 2, width of cfg_ch; must be max(1, ceil(log2(NUM_CH))).
- DEFAULT_DIV, 1, reset value of every channel's div (period = div+1 ticks).

Ports:
- clock, in, 1: sole clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- cmd_start, in, 1: IDLE->RUN, or PAUSE->RUN.
- cmd_pause, in, 1: RUN->PAUSE.
- cmd_stop, in, 1: any state->IDLE.
- cmd_step, in, 1: one tick while in PAUSE.
- cmd_sync, in, 1: zero all channel counters.
- cfg_we, in, 1: config write strobe.
- cfg_ch, in, CH_W: target channel.
- cfg_div, in, CNT_W: new divide value D.
- cfg_phase, in, CNT_W: new phase value P.
- ch_en, out, NUM_CH: one-cycle enable strobe per channel.
- ch_level, out, NUM_CH: divided square wave per channel.
- cfg_pending, out, NUM_CH: written config not yet applied.
- state, out, 2: 0=IDLE, 1=RUN, 2=PAUSE.

Behaviour:
- Reset (async, immediate): state=IDLE; all counters 0; ch_en=0; ch_level=0; cfg_pending=0; active and pending D=DEFAULT_DIV, P=0.
- FSM:
  - IDLE --start--> RUN.
  - RUN --pause--> PAUSE.
  - PAUSE --start--> RUN.
  - RUN/PAUSE --stop--> IDLE.
  - Encoding 3 is unreachable and is treated as IDLE.
- Command priority, same cycle: stop > sync > pause > start > step. Lower-priority commands that cycle are ignored.
- tick = (state==RUN) | (state==PAUSE & cmd_step & no higher-priority command).
- On tick, per channel i:
  - ch_en[i] <= (cnt_i == Peff_i), where Peff_i = min(P_i, D_i).
  - ch_level[i] <= (cnt_i >= ((D_i+1)>>1)).
  - cnt_i <= (cnt_i == D_i) ? 0 : cnt_i+1.
- Without tick: ch_en <= 0; ch_level and cnt hold.
- Outputs therefore reflect the count consumed one cycle earlier (1-cycle latency).
- D=0: period 1; ch_en high on every tick; ch_level constant 1 while ticking.
- Start latency: cmd_start sampled at edge k, RUN during cycle k+1 (first tick, cnt=0). A P=0 channel shows ch_en high in cycle k+2.
- Entering IDLE via stop: counters cleared, ch_en=0, ch_level=0 on the next cycle. Config (active and pending) is retained.
- Config write:
  - cfg_we with cfg_ch >= NUM_CH is ignored.
  - In IDLE: D/P load into the active registers immediately; cfg_pending stays 0.
  - In RUN/PAUSE: values go to the pending registers and cfg_pending[ch] is set. They transfer to active on that channel's wrap tick (tick with cnt_i==D_i), so the new period starts at cnt 0. cfg_pending[ch] clears on the same edge.
  - A second write before the wrap overwrites the pending values.
  - A write coinciding with the wrap tick goes to pending and applies at the next wrap.
- cmd_sync: all cnt <= 0; all pending config applied; cfg_pending <= 0; ch_en <= 0; ch_level held; state unchanged; no tick that cycle.
- Counters never exceed D_i. No arithmetic overflow; the wrap compare is on equality with D_i.

Test Plan:
- Config ch0 D=3,P=1 in IDLE; cmd_start at edge k -> ch_en[0] high in cycles k+3, k+7, k+11; ch_level[0]=0,0,1,1 repeating from cycle k+2; cfg_pending=0.
- RUN with ch1 D=1; write ch1 D=4,P=0 mid-period -> cfg_pending[1]=1 until ch1 wraps; afterwards ch_en[1] period is 5 cycles starting from cnt 0; ch0 timing undisturbed.
- RUN, cmd_pause -> state=2, ch_en all 0, levels frozen; three cmd_step pulses (gaps between) -> exactly three counter advances; ch_en only in the cycle after each step; cmd_start -> RUN resumes from the held count.
- ch2 D=2,P=7 -> Peff=2; ch_en[2] pulses on every third tick, aligned to cnt==2.
- ch0 D=3, ch1 D=5 running out of alignment; cmd_sync -> both counters 0; the next pulses of P=0 channels coincide two cycles later. cmd_stop+cmd_start in the same cycle -> IDLE, ch_en=0, ch_level=0.
- Assert reset mid-RUN, between edges -> state=0 and ch_en/ch_level/cfg_pending=0 immediately; after release, D=DEFAULT_DIV and P=0 on all channels; cfg_ch=NUM_CH write ignored.

Source files
------------

// File: rtl/clock_phase_gen.sv
// ============================================================================
// Module   : clock_phase_gen
// Brief    : Run/pause/step controlled per-channel clock-enable and level generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_phase_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int CH_W        = 2,
    parameter int DEFAULT_DIV = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    input  logic              cmd_step,
    input  logic              cmd_sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] ch_level,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_tick;
    logic   w_idle;

    // Priority stop > sync > pause > start > step; a lower command is dropped
    // whenever any higher one is present.
    logic w_do_stop, w_do_sync, w_do_pause, w_do_start, w_do_step;
    assign w_do_stop  = cmd_stop;
    assign w_do_sync  = cmd_sync  & ~cmd_stop;
    assign w_do_pause = cmd_pause & ~cmd_stop & ~cmd_sync;
    assign w_do_start = cmd_start & ~cmd_stop & ~cmd_sync & ~cmd_pause;
    assign w_do_step  = cmd_step  & ~cmd_stop & ~cmd_sync & ~cmd_pause & ~cmd_start;

    assign w_idle = (r_state != ST_RUN) && (r_state != ST_PAUSE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_tick = ~w_do_stop & ~w_do_sync;
                if (w_do_pause) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                w_tick = w_do_step;
                if (w_do_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                if (w_do_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
        if (w_do_stop) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign state = r_state;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_div;
            logic [CNT_W-1:0] r_phase;
            logic [CNT_W-1:0] r_pend_div;
            logic [CNT_W-1:0] r_pend_phase;
            logic             r_en;
            logic             r_lvl;
            logic             r_pend;
            logic             w_wrap;
            logic             w_wr;
            logic             w_apply;
            logic [CNT_W-1:0] w_peff;
            logic [CNT_W:0]   w_half;

            assign w_wrap  = (r_cnt == r_div);
            assign w_peff  = (r_phase < r_div) ? r_phase : r_div;
            assign w_half  = ({1'b0, r_div} + (CNT_W+1)'(1)) >> 1;
            assign w_wr    = cfg_we & (cfg_ch == CH_W'(i));
            // Pending config lands only at a period boundary or on resync.
            assign w_apply = r_pend & (w_do_sync | (w_tick & w_wrap));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_cnt        <= '0;
                    r_div        <= c_default_div;
                    r_phase      <= '0;
                    r_pend_div   <= c_default_div;
                    r_pend_phase <= '0;
                    r_en         <= 1'b0;
                    r_lvl        <= 1'b0;
                    r_pend       <= 1'b0;
                end else begin
                    if (w_do_stop) begin
                        r_cnt <= '0;
                        r_en  <= 1'b0;
                        r_lvl <= 1'b0;
                    end else if (w_do_sync) begin
                        r_cnt <= '0;
                        r_en  <= 1'b0;
                    end else if (w_tick) begin
                        r_en  <= (r_cnt == w_peff);
                        r_lvl <= ({1'b0, r_cnt} >= w_half);
                        r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                    end else begin
                        r_en <= 1'b0;
                    end

                    if (w_wr && !w_idle) begin
                        r_pend_div   <= cfg_div;
                        r_pend_phase <= cfg_phase;
                        r_pend       <= 1'b1;
                    end else if (w_apply) begin
                        r_pend <= 1'b0;
                    end

                    if (w_wr && w_idle) begin
                        r_div   <= cfg_div;
                        r_phase <= cfg_phase;
                    end else if (w_apply) begin
                        r_div   <= r_pend_div;
                        r_phase <= r_pend_phase;
                    end
                end
            end

            assign ch_en[i]       = r_en;
            assign ch_level[i]    = r_lvl;
            assign cfg_pending[i] = r_pend;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_phase_gen.sv
// ============================================================================
// Module   : tb_clock_phase_gen
// Brief    : Directed bench with a per-channel period/phase model of clock_phase_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_phase_gen;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;
    localparam int DD  = 1;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_start = 1'b0, cmd_pause = 1'b0, cmd_stop = 1'b0;
    logic           cmd_step = 1'b0, cmd_sync = 1'b0;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic [CW-1:0]  cfg_phase = '0;
    logic [NCH-1:0] ch_en, ch_level, cfg_pending;
    logic [1:0]     state;

    clock_phase_gen #(
        .NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW), .DEFAULT_DIV(DD)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .cmd_sync(cmd_sync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .ch_en(ch_en), .ch_level(ch_level), .cfg_pending(cfg_pending), .state(state)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is a position within a period of length D+1.
    int m_state;
    int m_pos[NCH], m_d[NCH], m_p[NCH], m_pd[NCH], m_pp[NCH];
    bit m_pf[NCH], m_en[NCH], m_lv[NCH];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0;
            for (int c = 0; c < NCH; c++) begin
                m_pos[c] = 0; m_d[c] = DD; m_p[c] = 0; m_pd[c] = DD; m_pp[c] = 0;
                m_pf[c] = 0; m_en[c] = 0; m_lv[c] = 0;
            end
        end else begin
            bit stop, sync, pause, start, step, tick;
            int old;
            old   = m_state;
            stop  = cmd_stop;
            sync  = !stop && cmd_sync;
            pause = !stop && !sync && cmd_pause;
            start = !stop && !sync && !pause && cmd_start;
            step  = !stop && !sync && !pause && !start && cmd_step;
            tick  = (old == 1 && !stop && !sync) || (old == 2 && step);
            if (stop) m_state = 0;
            else if (pause && old == 1) m_state = 2;
            else if (start && old != 1) m_state = 1;
            for (int c = 0; c < NCH; c++) begin
                if (stop) begin
                    m_pos[c] = 0; m_en[c] = 0; m_lv[c] = 0;
                end else if (sync) begin
                    m_pos[c] = 0; m_en[c] = 0;
                    if (m_pf[c]) begin m_d[c] = m_pd[c]; m_p[c] = m_pp[c]; m_pf[c] = 0; end
                end else if (tick) begin
                    m_en[c] = (m_pos[c] == ((m_p[c] < m_d[c]) ? m_p[c] : m_d[c]));
                    m_lv[c] = (m_pos[c] >= (m_d[c] + 1) / 2);
                    if (m_pos[c] == m_d[c]) begin
                        m_pos[c] = 0;
                        if (m_pf[c]) begin m_d[c] = m_pd[c]; m_p[c] = m_pp[c]; m_pf[c] = 0; end
                    end else begin
                        m_pos[c] = m_pos[c] + 1;
                    end
                end else begin
                    m_en[c] = 0;
                end
            end
            if (cfg_we && int'(cfg_ch) < NCH) begin
                if (old == 0) begin
                    m_d[cfg_ch] = int'(cfg_div); m_p[cfg_ch] = int'(cfg_phase);
                end else begin
                    m_pd[cfg_ch] = int'(cfg_div); m_pp[cfg_ch] = int'(cfg_phase);
                    m_pf[cfg_ch] = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            logic [NCH-1:0] e, l, p;
            for (int c = 0; c < NCH; c++) begin
                e[c] = m_en[c]; l[c] = m_lv[c]; p[c] = m_pf[c];
            end
            chk("model_state", int'(state), m_state);
            chk("model_ch_en", int'(ch_en), int'(e));
            chk("model_ch_level", int'(ch_level), int'(l));
            chk("model_cfg_pending", int'(cfg_pending), int'(p));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input int ch, input int d, input int p);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_div = CW'(d); cfg_phase = CW'(p);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic cmd(input bit st, input bit pa, input bit sp, input bit se, input bit sy);
        cmd_start = st; cmd_pause = pa; cmd_stop = sp; cmd_step = se; cmd_sync = sy;
        cyc();
        cmd_start = 0; cmd_pause = 0; cmd_stop = 0; cmd_step = 0; cmd_sync = 0;
    endtask

    initial begin
        bit done;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_state", int'(state), 0);
        chk("reset_en_level_pend", int'({ch_en, ch_level, cfg_pending}), 0);
        chk_on = 1'b1;

        // IDLE config: ch0 D=3 P=1, ch2 D=2 P=7 (phase clamps to 2)
        cfg(0, 3, 1);
        cfg(2, 2, 7);
        cmd(1, 0, 0, 0, 0);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clock);
            chk("start_en0", int'(ch_en[0]), (j == 3 || j == 7) ? 1 : 0);
            chk("start_lvl0", int'(ch_level[0]), (j == 4 || j == 5 || j == 8 || j == 9) ? 1 : 0);
            chk("start_en2", int'(ch_en[2]), (j == 4 || j == 7) ? 1 : 0);
            if (j == 1) chk("start_pending", int'(cfg_pending), 0);
            cyc();
        end

        // mid-run rewrite of ch1 to D=4 P=0
        cfg(1, 4, 0);
        @(negedge clock);
        chk("pend1_set", int'(cfg_pending[1]), 1);
        done = 0;
        for (int n = 0; n < 10 && !done; n++) begin
            cyc();
            @(negedge clock);
            if (!cfg_pending[1]) done = 1;
        end
        chk("pend1_cleared", int'(done), 1);
        for (int j = 0; j <= 5; j++) begin
            cyc();
            @(negedge clock);
            chk("new_period_en1", int'(ch_en[1]), (j == 0 || j == 5) ? 1 : 0);
        end

        // pause, three separated steps, resume
        cyc();
        cmd(0, 1, 0, 0, 0);
        @(negedge clock);
        chk("pause_state", int'(state), 2);
        cyc();
        @(negedge clock);
        chk("pause_en_zero", int'(ch_en), 0);
        for (int s = 0; s < 3; s++) begin
            cmd(0, 0, 0, 1, 0);
            cyc();
            cyc();
        end
        cmd(1, 0, 0, 0, 0);
        @(negedge clock);
        chk("resume_state", int'(state), 1);

        // resync of misaligned ch0 D=3 and ch1 D=5 (both P=0)
        cfg(0, 3, 0);
        cfg(1, 5, 0);
        repeat (23) cyc();
        cmd(0, 0, 0, 0, 1);
        @(negedge clock);
        chk("sync_en_zero", int'(ch_en), 0);
        chk("sync_pend_zero", int'(cfg_pending), 0);
        cyc();
        @(negedge clock);
        chk("sync_aligned_en", int'(ch_en), 3);
        repeat (8) cyc();

        // stop beats start in the same cycle
        cmd(1, 0, 1, 0, 0);
        @(negedge clock);
        chk("stop_state", int'(state), 0);
        chk("stop_en_level", int'({ch_en, ch_level}), 0);

        // async reset mid-run with a pending write outstanding
        cmd(1, 0, 0, 0, 0);
        repeat (5) cyc();
        cfg(0, 1, 1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_outputs", int'({ch_en, ch_level, cfg_pending}), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        cfg(3, 0, 0);
        cmd(1, 0, 0, 0, 0);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clock);
            chk("default_div_en", int'(ch_en), (j % 2 == 0) ? 7 : 0);
            chk("default_div_lvl", int'(ch_level), (j >= 3 && j % 2 == 1) ? 7 : 0);
            cyc();
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
